mt_fill_ctrl: RTL and testbench
===============================

Name: mt_fill_ctrl

Overview:
Sequencer for the mt19937 generator and the single-port ram.
- On a start command it seeds the generator and waits for seeding to finish.
- It then streams FILL_COUNT random words into consecutive RAM addresses through the generator's valid/ready handshake.
- Between fills it arbitrates the shared RAM port, so a host can read back the stored words.

Parameters:
NUM_BITS, 32, word width of generator output and RAM data
ADDR_WIDTH, 8, RAM address width
FILL_COUNT, 10, words written per fill (1..2**ADDR_WIDTH)
BASE_ADDR, 0, first RAM address written
SEED_TIMEOUT, 4096, max cycles waiting for mt_busy to drop before flagging error

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin seed+fill; honoured only in IDLE or DONE
seed_in  in  NUM_BITS  seed value, sampled on the accepted start cycle
busy  out  1  high in SEED, WAIT_SEED, FILL
done  out  1  high in DONE until next start
error  out  1  sticky seed-timeout flag; cleared by an accepted start or by reset
mt_seed_val  out  NUM_BITS  latched seed to generator
mt_seed_start  out  1  one-cycle seed pulse
mt_busy  in  1  generator seeding in progress
mt_r_num  in  NUM_BITS  generator output word
mt_valid  in  1  generator output valid
mt_ready  out  1  controller accepts word
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_oe  out  1  RAM output enable
ram_addr  out  ADDR_WIDTH  RAM address
ram_din  out  NUM_BITS  RAM write data
ram_dout  in  NUM_BITS  RAM read data
rd_req  in  1  host read request
rd_addr  in  ADDR_WIDTH  host read address
rd_gnt  out  1  read request accepted this cycle
rd_valid  out  1  rd_data valid, one cycle after rd_gnt
rd_data  out  NUM_BITS  read data

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0.
  - mt_seed_val 0.
  - Write pointer = BASE_ADDR.
  - error 0.
- State IDLE:
  - Accepted start latches seed_in into mt_seed_val and clears error.
  - Next state is SEED.
- State SEED:
  - mt_seed_start=1 for exactly this one cycle.
  - Write pointer is set to BASE_ADDR and the word counter to 0.
  - Next state is WAIT_SEED.
- State WAIT_SEED:
  - Ignore mt_busy during the first cycle, which covers the generator's latency in raising busy.
  - Afterwards, mt_busy==0 moves the state to FILL.
  - A timeout counter reaching SEED_TIMEOUT sets error and moves the state to IDLE.
- State FILL:
  - mt_ready=1.
  - A transfer occurs in any cycle where mt_valid && mt_ready.
  - On a transfer, combinationally in the same cycle: ram_cs=1, ram_we=1, ram_oe=0, ram_addr=write pointer, ram_din=mt_r_num.
  - On each transfer the pointer and counter increment.
  - The pointer wraps modulo 2**ADDR_WIDTH.
  - The transfer that makes counter==FILL_COUNT moves the state to DONE; mt_ready drops in the next cycle.
  - Cycles without mt_valid drive no RAM access.
- State DONE:
  - done=1.
  - An accepted start behaves as from IDLE.
- Read arbitration:
  - The fill owns the RAM in SEED, WAIT_SEED and FILL.
  - rd_req in those states gets rd_gnt=0; the host holds the request.
  - In IDLE/DONE, rd_req gives combinational rd_gnt=1 and drives ram_cs=1, ram_oe=1, ram_we=0, ram_addr=rd_addr.
  - The RAM read is registered: the next cycle gives rd_valid=1 and rd_data=ram_dout.
  - Back-to-back reads sustain one per cycle.
- Simultaneous start and rd_req in IDLE/DONE:
  - The read is granted that cycle; the start is also accepted.
  - The pending rd_valid still completes in SEED.
- Reset mid-fill: all state is lost; RAM contents are undefined/partial and done=0.
- start while busy is ignored and is not queued.

Decomposition:
- Shared package holds:
  - A state enum (IDLE, SEED, WAIT_SEED, FILL, DONE) as localparams.
  - The NUM_BITS/ADDR_WIDTH defaults shared with mt19937 and ram.
- One natural sub-module, mt_fill_rd_arb: the RAM port mux plus the rd_valid pipeline register.
- The FSM, counters and timeout stay in the top module.

Test Plan:
- Reset, then start with seed_in=5489 and FILL_COUNT=10 -> mt_seed_start pulses once; fill begins after mt_busy falls; RAM[0..9] equals the first 10 mt19937 outputs (RAM[0]=3499211612); done=1.
- Stall the generator by forcing mt_valid low for 3 cycles mid-fill -> no RAM writes during the stall; the remaining words land at consecutive addresses with no gaps or duplicates.
- After done, issue rd_req with rd_addr 0..9 back-to-back -> rd_valid on cycles 1..10 with rd_data matching the stored words.
- rd_req during FILL -> rd_gnt stays 0 until DONE, then the read is served; fill data is uncorrupted.
- Hold mt_busy=1 for SEED_TIMEOUT+5 cycles -> error=1, state IDLE, no RAM writes; a following start clears error.
- BASE_ADDR=250, FILL_COUNT=10, ADDR_WIDTH=8 -> writes go to 250..255 then 0..3; deasserting rst_n mid-fill -> all outputs zero immediately.

Source files
------------

// File: rtl/mt_fill_ctrl_pkg.sv
// Shared types and default widths for the mt19937 fill sequencer.
// The width defaults match the mt19937 generator and the single-port RAM.
package mt_fill_ctrl_pkg;

    localparam int MT_NUM_BITS   = 32;
    localparam int MT_ADDR_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEED      = 3'd1,
        ST_WAIT_SEED = 3'd2,
        ST_FILL      = 3'd3,
        ST_DONE      = 3'd4
    } fill_state_e;

endpackage

// File: rtl/mt_fill_rd_arb.sv
// Shared RAM port mux: fill writes while the sequencer owns the RAM, host reads otherwise.
// Read data comes from a synchronous RAM, so rd_valid trails rd_gnt by one cycle.
module mt_fill_rd_arb
    import mt_fill_ctrl_pkg::*;
#(
    parameter int NUM_BITS   = MT_NUM_BITS,
    parameter int ADDR_WIDTH = MT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fill_owns,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_BITS-1:0]   wr_data,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [NUM_BITS-1:0]   rd_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [NUM_BITS-1:0]   ram_din,
    input  logic [NUM_BITS-1:0]   ram_dout
);

    always_comb begin
        rd_gnt   = rd_req && !fill_owns;
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_oe   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (wr_en) begin
            ram_cs   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = wr_addr;
            ram_din  = wr_data;
        end else if (rd_gnt) begin
            ram_cs   = 1'b1;
            ram_oe   = 1'b1;
            ram_addr = rd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_gnt;
        end
    end

    assign rd_data = rd_valid ? ram_dout : '0;

endmodule

// File: rtl/mt_fill_ctrl.sv
// Seeds the mt19937 generator, streams FILL_COUNT words into RAM, and lets a host read back between fills.
// state     | meaning
// IDLE      | waiting for start, host may read RAM
// SEED      | one-cycle seed pulse, pointers reset
// WAIT_SEED | waiting for mt_busy to drop, bounded by SEED_TIMEOUT
// FILL      | accepting generator words into consecutive addresses
// DONE      | fill complete, host may read RAM
module mt_fill_ctrl
    import mt_fill_ctrl_pkg::*;
#(
    parameter int NUM_BITS     = MT_NUM_BITS,
    parameter int ADDR_WIDTH   = MT_ADDR_WIDTH,
    parameter int FILL_COUNT   = 10,
    parameter int BASE_ADDR    = 0,
    parameter int SEED_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NUM_BITS-1:0]   seed_in,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [NUM_BITS-1:0]   mt_seed_val,
    output logic                  mt_seed_start,
    input  logic                  mt_busy,
    input  logic [NUM_BITS-1:0]   mt_r_num,
    input  logic                  mt_valid,
    output logic                  mt_ready,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [NUM_BITS-1:0]   ram_din,
    input  logic [NUM_BITS-1:0]   ram_dout,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [NUM_BITS-1:0]   rd_data
);

    localparam int CNT_W = $clog2(FILL_COUNT + 1);
    localparam int TMO_W = $clog2(SEED_TIMEOUT + 1);

    fill_state_e           state, state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [CNT_W-1:0]      word_cnt;
    logic [TMO_W-1:0]      tmo_cnt;

    logic start_ok, xfer, last_word, tmo_first, seed_ok, tmo_expire;

    assign start_ok   = start && (state == ST_IDLE || state == ST_DONE);
    assign xfer       = (state == ST_FILL) && mt_valid;
    assign last_word  = (word_cnt == CNT_W'(FILL_COUNT - 1));
    // Timer is loaded with SEED_TIMEOUT, so a full count marks the first WAIT_SEED cycle.
    assign tmo_first  = (tmo_cnt == TMO_W'(SEED_TIMEOUT));
    assign seed_ok    = (state == ST_WAIT_SEED) && !tmo_first && !mt_busy;
    assign tmo_expire = (state == ST_WAIT_SEED) && !seed_ok && (tmo_cnt == TMO_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start_ok)           state_nxt = ST_SEED;
            ST_SEED:                                  state_nxt = ST_WAIT_SEED;
            ST_WAIT_SEED: begin
                if (seed_ok)                          state_nxt = ST_FILL;
                else if (tmo_expire)                  state_nxt = ST_IDLE;
            end
            ST_FILL:      if (xfer && last_word)      state_nxt = ST_DONE;
            default:                                  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        mt_seed_start = 1'b0;
        mt_ready      = 1'b0;
        case (state)
            ST_SEED: begin
                busy          = 1'b1;
                mt_seed_start = 1'b1;
            end
            ST_WAIT_SEED: busy = 1'b1;
            ST_FILL: begin
                busy     = 1'b1;
                mt_ready = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mt_seed_val <= '0;
            error       <= 1'b0;
            wr_ptr      <= ADDR_WIDTH'(BASE_ADDR);
            word_cnt    <= '0;
            tmo_cnt     <= '0;
        end else begin
            if (start_ok) begin
                mt_seed_val <= seed_in;
                error       <= 1'b0;
            end
            if (state == ST_SEED) begin
                wr_ptr   <= ADDR_WIDTH'(BASE_ADDR);
                word_cnt <= '0;
                tmo_cnt  <= TMO_W'(SEED_TIMEOUT);
            end
            if (state == ST_WAIT_SEED) begin
                tmo_cnt <= tmo_cnt - TMO_W'(1);
            end
            if (tmo_expire) begin
                error <= 1'b1;
            end
            if (xfer) begin
                wr_ptr   <= wr_ptr + ADDR_WIDTH'(1);
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

    mt_fill_rd_arb #(
        .NUM_BITS   (NUM_BITS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill_owns (busy),
        .wr_en     (xfer),
        .wr_addr   (wr_ptr),
        .wr_data   (mt_r_num),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

endmodule

// File: tb/tb_mt_fill_ctrl.sv
// Directed bench for mt_fill_ctrl: seed/fill, stall, readback, read arbitration, timeout, wrap and reset.
module tb_mt_fill_ctrl;

    localparam int TMO = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] seed_in = '0;
    logic        busy, done, error, mt_seed_start, mt_ready;
    logic [31:0] mt_seed_val;
    logic        mt_busy = 1'b0;
    logic [31:0] mt_r_num = '0;
    logic        mt_valid = 1'b0;
    logic        ram_cs, ram_we, ram_oe;
    logic [7:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = '0;
    logic        rd_req = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        rd_gnt, rd_valid;
    logic [31:0] rd_data;

    logic        w_rst_n = 1'b0;
    logic        w_start = 1'b0;
    logic [31:0] w_seed_in = '0;
    logic        w_busy, w_done, w_error, w_mt_seed_start, w_mt_ready;
    logic [31:0] w_mt_seed_val;
    logic        w_mt_busy = 1'b0;
    logic [31:0] w_mt_r_num = '0;
    logic        w_mt_valid = 1'b0;
    logic        w_ram_cs, w_ram_we, w_ram_oe;
    logic [7:0]  w_ram_addr;
    logic [31:0] w_ram_din;
    logic [31:0] w_ram_dout = '0;
    logic        w_rd_req = 1'b0;
    logic [7:0]  w_rd_addr = '0;
    logic        w_rd_gnt, w_rd_valid;
    logic [31:0] w_rd_data;

    int n_vec = 0;
    int n_fail = 0;
    int wr_count = 0;
    int seed_pulses = 0;
    logic [31:0] mem [256];
    logic [31:0] mt_words [10];
    logic [31:0] words2 [10];

    always #5 clk = ~clk;

    mt_fill_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed_in(seed_in),
        .busy(busy), .done(done), .error(error),
        .mt_seed_val(mt_seed_val), .mt_seed_start(mt_seed_start),
        .mt_busy(mt_busy), .mt_r_num(mt_r_num), .mt_valid(mt_valid), .mt_ready(mt_ready),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    mt_fill_ctrl #(.BASE_ADDR(250)) dut_w (
        .clk(clk), .rst_n(w_rst_n), .start(w_start), .seed_in(w_seed_in),
        .busy(w_busy), .done(w_done), .error(w_error),
        .mt_seed_val(w_mt_seed_val), .mt_seed_start(w_mt_seed_start),
        .mt_busy(w_mt_busy), .mt_r_num(w_mt_r_num), .mt_valid(w_mt_valid), .mt_ready(w_mt_ready),
        .ram_cs(w_ram_cs), .ram_we(w_ram_we), .ram_oe(w_ram_oe), .ram_addr(w_ram_addr),
        .ram_din(w_ram_din), .ram_dout(w_ram_dout),
        .rd_req(w_rd_req), .rd_addr(w_rd_addr), .rd_gnt(w_rd_gnt), .rd_valid(w_rd_valid), .rd_data(w_rd_data)
    );

    // Behavioural synchronous single-port RAM and write/seed monitors
    always @(posedge clk) begin
        if (ram_cs && ram_we) begin
            mem[ram_addr] <= ram_din;
            wr_count      <= wr_count + 1;
        end
        if (ram_cs && ram_oe) ram_dout <= mem[ram_addr];
        if (mt_seed_start) seed_pulses <= seed_pulses + 1;
    end

    task automatic do_start(input logic [31:0] s);
        start = 1'b1;
        seed_in = s;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_fill(input logic [31:0] w [10], input int stall_at);
        int idx = 0;
        int stalled = 0;
        int cyc = 0;
        logic [7:0] ea;
        while (!mt_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_vec++;
        if (mt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_ready_wait: mt_ready=%b required 1", mt_ready);
        end
        while (idx < 10 && cyc < 200) begin
            if (idx == stall_at && stalled < 3) begin
                mt_valid = 1'b0;
                stalled++;
            end else begin
                mt_valid = 1'b1;
                mt_r_num = w[idx];
            end
            @(negedge clk);
            ea = 8'(idx);
            n_vec++;
            if (mt_valid) begin
                if ({mt_ready, ram_cs, ram_we, ram_oe, rd_gnt} !== 5'b11100 || ram_addr !== ea || ram_din !== w[idx]) begin
                    n_fail++;
                    $display("FAIL fill_write[%0d]: ctl=%b addr=%0d din=%h required ctl=11100 addr=%0d din=%h",
                             idx, {mt_ready, ram_cs, ram_we, ram_oe, rd_gnt}, ram_addr, ram_din, ea, w[idx]);
                end
            end else if ({ram_cs, ram_we, rd_gnt} !== 3'b000) begin
                n_fail++;
                $display("FAIL fill_stall: cs/we/gnt=%b required 000", {ram_cs, ram_we, rd_gnt});
            end
            @(posedge clk); #1;
            if (mt_valid) idx++;
            cyc++;
        end
        mt_valid = 1'b0;
        n_vec++;
        if (idx != 10 || done !== 1'b1 || mt_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_end: words=%0d done=%b ready=%b required 10 1 0", idx, done, mt_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, error, mt_seed_start, mt_ready, ram_cs, ram_we, ram_oe, rd_gnt, rd_valid} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: %b required 0", {busy, done, error, mt_seed_start, mt_ready, ram_cs, ram_we, ram_oe, rd_gnt, rd_valid});
        end
        n_vec++;
        if (mt_seed_val !== 32'd0 || ram_addr !== 8'd0 || rd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: seed=%h addr=%h rd=%h required 0", mt_seed_val, ram_addr, rd_data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_seed_fill();
        mt_busy = 1'b0;
        do_start(32'd5489);
        n_vec++;
        if (mt_seed_start !== 1'b1 || mt_seed_val !== 32'd5489 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL seed_pulse: start=%b val=%0d busy=%b required 1 5489 1", mt_seed_start, mt_seed_val, busy);
        end
        @(posedge clk); #1;
        n_vec++;
        if (mt_seed_start !== 1'b0 || mt_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL seed_one_cycle: start=%b ready=%b required 0 0", mt_seed_start, mt_ready);
        end
        @(posedge clk); #1;
        n_vec++;
        if (mt_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_latency_ignored: ready=%b busy=%b required 0 1", mt_ready, busy);
        end
        mt_busy = 1'b1;
        start = 1'b1;
        seed_in = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++;
        if (mt_seed_val !== 32'd5489 || mt_seed_start !== 1'b0) begin
            n_fail++;
            $display("FAIL start_while_busy: val=%h pulse=%b required 5489 0", mt_seed_val, mt_seed_start);
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (mt_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_while_mt_busy: ready=%b required 0", mt_ready);
        end
        mt_busy = 1'b0;
        run_fill(mt_words, 4);
        n_vec++;
        if (wr_count != 10 || seed_pulses != 1 || mem[0] !== 32'd3499211612) begin
            n_fail++;
            $display("FAIL fill_totals: writes=%0d pulses=%0d ram0=%0d required 10 1 3499211612", wr_count, seed_pulses, mem[0]);
        end
    endtask

    task automatic test_back_to_back_reads();
        for (int i = 0; i <= 10; i++) begin
            rd_req = (i < 10);
            rd_addr = 8'(i);
            @(negedge clk);
            n_vec++;
            if (i < 10 && ({rd_gnt, ram_cs, ram_oe, ram_we} !== 4'b1110 || ram_addr !== 8'(i))) begin
                n_fail++;
                $display("FAIL read_grant[%0d]: gnt/cs/oe/we=%b addr=%0d required 1110 %0d", i, {rd_gnt, ram_cs, ram_oe, ram_we}, ram_addr, i);
            end
            if (i > 0 && (rd_valid !== 1'b1 || rd_data !== mt_words[i-1])) begin
                n_fail++;
                $display("FAIL read_data[%0d]: valid=%b data=%0d required 1 %0d", i-1, rd_valid, rd_data, mt_words[i-1]);
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_idle: rd_valid=%b required 0", rd_valid);
        end
    endtask

    task automatic test_read_during_fill();
        do_start(32'h1234);
        rd_req = 1'b1;
        rd_addr = 8'd3;
        #1;
        n_vec++;
        if (rd_gnt !== 1'b0 || ram_cs !== 1'b0) begin
            n_fail++;
            $display("FAIL read_blocked_seed: gnt=%b cs=%b required 0 0", rd_gnt, ram_cs);
        end
        run_fill(words2, 99);
        n_vec++;
        if (rd_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL read_after_done_gnt: gnt=%b required 1", rd_gnt);
        end
        @(posedge clk); #1;
        rd_req = 1'b0;
        n_vec++;
        if (rd_valid !== 1'b1 || rd_data !== words2[3]) begin
            n_fail++;
            $display("FAIL read_after_done_data: valid=%b data=%h required 1 %h", rd_valid, rd_data, words2[3]);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int wc0;
        mt_busy = 1'b1;
        start = 1'b1;
        seed_in = 32'd7;
        rd_req = 1'b1;
        rd_addr = 8'd5;
        #1;
        n_vec++;
        if (rd_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL start_with_read_gnt: gnt=%b required 1", rd_gnt);
        end
        @(posedge clk); #1;
        start = 1'b0;
        rd_req = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || rd_valid !== 1'b1 || rd_data !== words2[5] || mt_seed_start !== 1'b1) begin
            n_fail++;
            $display("FAIL start_with_read_data: busy=%b valid=%b data=%h pulse=%b required 1 1 %h 1",
                     busy, rd_valid, rd_data, mt_seed_start, words2[5]);
        end
        wc0 = wr_count;
        while (busy && n < TMO + 5) begin
            @(posedge clk); #1;
            n++;
        end
        n_vec++;
        if (n != TMO + 1 || error !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || wr_count != wc0) begin
            n_fail++;
            $display("FAIL seed_timeout: cycles=%0d err=%b busy=%b done=%b writes=%0d required %0d 1 0 0 0",
                     n, error, busy, done, wr_count - wc0, TMO + 1);
        end
        mt_busy = 1'b0;
        do_start(32'd9);
        n_vec++;
        if (error !== 1'b0 || mt_seed_val !== 32'd9) begin
            n_fail++;
            $display("FAIL error_clear: err=%b val=%0d required 0 9", error, mt_seed_val);
        end
        run_fill(mt_words, 0);
    endtask

    task automatic test_wrap_and_reset();
        int cyc = 0;
        logic [7:0] ea;
        w_rst_n = 1'b1;
        @(posedge clk); #1;
        w_start = 1'b1;
        w_seed_in = 32'd1;
        @(posedge clk); #1;
        w_start = 1'b0;
        while (!w_mt_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        for (int i = 0; i < 10; i++) begin
            w_mt_valid = 1'b1;
            w_mt_r_num = 32'hC000_0000 + 32'(i);
            ea = 8'd250 + 8'(i);
            @(negedge clk);
            n_vec++;
            if ({w_ram_cs, w_ram_we} !== 2'b11 || w_ram_addr !== ea || w_ram_din !== w_mt_r_num) begin
                n_fail++;
                $display("FAIL wrap_write[%0d]: cs/we=%b addr=%0d din=%h required 11 %0d %h",
                         i, {w_ram_cs, w_ram_we}, w_ram_addr, w_ram_din, ea, w_mt_r_num);
            end
            @(posedge clk); #1;
        end
        w_mt_valid = 1'b0;
        n_vec++;
        if (w_done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_done: done=%b required 1", w_done);
        end
        w_start = 1'b1;
        @(posedge clk); #1;
        w_start = 1'b0;
        repeat (2) @(posedge clk);
        w_mt_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        w_rst_n = 1'b0;
        #1;
        n_vec++;
        if ({w_busy, w_done, w_error, w_mt_seed_start, w_mt_ready, w_ram_cs, w_ram_we, w_ram_oe, w_rd_gnt, w_rd_valid} !== 10'b0 ||
            w_ram_addr !== 8'd0 || w_ram_din !== 32'd0 || w_mt_seed_val !== 32'd0 || w_rd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_fill: ctl=%b addr=%h din=%h seed=%h required all 0",
                     {w_busy, w_done, w_error, w_mt_seed_start, w_mt_ready, w_ram_cs, w_ram_we, w_ram_oe, w_rd_gnt, w_rd_valid},
                     w_ram_addr, w_ram_din, w_mt_seed_val);
        end
        w_mt_valid = 1'b0;
    endtask

    initial begin
        mt_words = '{32'd3499211612, 32'd581869302, 32'd3890346734, 32'd3586334585, 32'd545404204,
                     32'd4161255391, 32'd3922919429, 32'd949333985, 32'd2715962298, 32'd1323567403};
        for (int i = 0; i < 10; i++) words2[i] = 32'hA5A5_0000 + 32'(i * 257);
        test_reset();
        test_seed_fill();
        test_back_to_back_reads();
        test_read_during_fill();
        test_timeout();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
